// File: rtl/pulse_sequence_scheduler.sv
// Shot sequencer for the three_pulse core: latches a timing word and fires repeated
// RF_signal_valid windows with idle gaps. Optional macro PHASE_CYCLE_EN adds phase_offset.
module pulse_sequence_scheduler #(
    parameter int REP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [191:0]     cfg_timing,
    input  logic [REP_W-1:0] cfg_repeats,
    input  logic [31:0]      cfg_rep_delay,
    output logic [191:0]     pulse_timing_data,
    output logic             RF_signal_valid,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] shot_count
`ifdef PHASE_CYCLE_EN
    ,
    output logic [1:0]       phase_offset
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, FIN} state_t;

    state_t           state;
    logic [191:0]     timing_lat;
    logic [REP_W-1:0] repeats_lat;
    logic [31:0]      delay_lat;
    logic [34:0]      seq_cycles;
    logic [34:0]      run_cnt;
    logic [31:0]      gap_cnt;
    logic             sum_ready;
    logic [34:0]      timing_sum;
    logic [31:0]      gap_end;

    always_comb begin
        timing_sum = '0;
        for (int i = 0; i < 6; i++)
            timing_sum = timing_sum + 35'(timing_lat[i*32 +: 32]);
    end

    assign gap_end = (delay_lat == 32'd0) ? 32'd1 : delay_lat;
    assign busy    = (state != IDLE);

    // LOAD spends one cycle summing the fields and one arming the first shot,
    // which places the RF_signal_valid rise two edges after the accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            timing_lat        <= '0;
            repeats_lat       <= '0;
            delay_lat         <= '0;
            seq_cycles        <= '0;
            run_cnt           <= '0;
            gap_cnt           <= '0;
            sum_ready         <= 1'b0;
            pulse_timing_data <= '0;
            RF_signal_valid   <= 1'b0;
            done              <= 1'b0;
            shot_count        <= '0;
`ifdef PHASE_CYCLE_EN
            phase_offset      <= 2'd0;
`endif
        end else if (abort) begin
            state           <= IDLE;
            RF_signal_valid <= 1'b0;
            done            <= 1'b0;
            sum_ready       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        timing_lat  <= cfg_timing;
                        repeats_lat <= cfg_repeats;
                        delay_lat   <= cfg_rep_delay;
                        shot_count  <= '0;
`ifdef PHASE_CYCLE_EN
                        phase_offset <= 2'd0;
`endif
                        sum_ready   <= 1'b0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    pulse_timing_data <= timing_lat;
                    if (!sum_ready) begin
                        seq_cycles <= (timing_sum == 35'd0) ? 35'd1 : timing_sum;
                        if (repeats_lat == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            sum_ready <= 1'b1;
                        end
                    end else begin
                        sum_ready       <= 1'b0;
                        run_cnt         <= 35'd1;
                        RF_signal_valid <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    if (run_cnt == seq_cycles) begin
                        RF_signal_valid <= 1'b0;
                        shot_count      <= shot_count + REP_W'(1);
`ifdef PHASE_CYCLE_EN
                        phase_offset    <= phase_offset + 2'd1;
`endif
                        if (shot_count + REP_W'(1) == repeats_lat) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            gap_cnt <= 32'd1;
                            state   <= GAP;
                        end
                    end else begin
                        run_cnt <= run_cnt + 35'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == gap_end) begin
                        run_cnt         <= 35'd1;
                        RF_signal_valid <= 1'b1;
                        state           <= RUN;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_sequence_scheduler.sv
// Bench for pulse_sequence_scheduler: a timeline model derived from run parameters,
// checked every cycle, plus hand-computed literals for the directed scenarios.
module tb_pulse_sequence_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [191:0] cfg_timing = '0;
    logic [15:0]  cfg_repeats = '0;
    logic [31:0]  cfg_rep_delay = '0;
    logic [191:0] pulse_timing_data;
    logic         RF_signal_valid;
    logic         busy;
    logic         done;
    logic [15:0]  shot_count;
`ifdef PHASE_CYCLE_EN
    logic [1:0]   phase_offset;
    logic [1:0]   ph_rise [8];
`endif

    pulse_sequence_scheduler #(.REP_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_timing(cfg_timing), .cfg_repeats(cfg_repeats), .cfg_rep_delay(cfg_rep_delay),
        .pulse_timing_data(pulse_timing_data), .RF_signal_valid(RF_signal_valid),
        .busy(busy), .done(done), .shot_count(shot_count)
`ifdef PHASE_CYCLE_EN
        , .phase_offset(phase_offset)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int nprint = 0;

    // Run description: start accepted at edge t0, S-cycle shots, G-cycle gaps, R shots.
    bit           active = 1'b0;
    int           t0, S, G, R;
    int           ab_at = 32'h7fffffff;
    logic [191:0] tim, prev_ptd = '0;
    int           prev_sc = 0;

    function automatic logic [191:0] pack(input logic [31:0] a, b, c, d, e, f);
        return {a, b, c, d, e, f};
    endfunction

    function automatic longint tsum(input logic [191:0] t);
        longint s = 0;
        for (int i = 0; i < 6; i++) s += longint'(t[i*32 +: 32]);
        return s;
    endfunction

    function automatic void nominal(input int c, output bit rf, output bit bz, output bit dn,
                                    output int sc, output logic [191:0] ptd);
        int d, per, p, e;
        rf = 0; bz = 0; dn = 0; sc = prev_sc; ptd = prev_ptd;
        d = c - t0;
        if (!active || d < 0) return;
        ptd = (d >= 1) ? tim : prev_ptd;
        if (R == 0) begin
            bz = (d <= 1); dn = (d == 1); sc = 0;
            return;
        end
        per = S + G;
        e   = 2 + R*S + (R-1)*G;
        bz  = (d <= e);
        dn  = (d == e);
        if (d < 2) sc = 0;
        else if (d >= e) sc = R;
        else begin
            p  = (d - 2) % per;
            rf = (p < S);
            sc = (d - 2) / per + ((p >= S) ? 1 : 0);
        end
    endfunction

    function automatic void model(input int c, output bit rf, output bit bz, output bit dn,
                                  output int sc, output logic [191:0] ptd);
        if (active && c >= ab_at) begin
            nominal(ab_at - 1, rf, bz, dn, sc, ptd);
            rf = 0; bz = 0; dn = 0;
        end else begin
            nominal(c, rf, bz, dn, sc, ptd);
        end
    endfunction

    always @(negedge clk) begin
        bit e_rf, e_bz, e_dn, ok;
        int e_sc;
        logic [191:0] e_ptd;
        if (!rst) begin
            model(cyc, e_rf, e_bz, e_dn, e_sc, e_ptd);
            ok = (RF_signal_valid === e_rf) && (busy === e_bz) && (done === e_dn) &&
                 (shot_count === 16'(e_sc)) && (pulse_timing_data === e_ptd);
`ifdef PHASE_CYCLE_EN
            ok = ok && (phase_offset === 2'(e_sc % 4));
`endif
            tests++;
            if (!ok) begin
                fails++;
                if (nprint < 20)
                    $display("FAIL cycle_model @%0d: rf=%0b/%0b busy=%0b/%0b done=%0b/%0b sc=%0d/%0d ptd_ok=%0b (got/expected)",
                             cyc, RF_signal_valid, e_rf, busy, e_bz, done, e_dn, shot_count, e_sc,
                             pulse_timing_data === e_ptd);
                nprint++;
            end
        end
    end

    // Event monitor for the literal checks.
    int hi_cnt, done_cnt, busy_cnt, rise_cyc, done_cyc, nrise;
    logic rf_q = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (RF_signal_valid && !rf_q) begin
                if (nrise == 0) rise_cyc = cyc;
`ifdef PHASE_CYCLE_EN
                if (nrise < 8) ph_rise[nrise] = phase_offset;
`endif
                nrise++;
            end
            rf_q = RF_signal_valid;
            if (RF_signal_valid) hi_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy) busy_cnt++;
        end else begin
            rf_q = 1'b0;
        end
    end

    task automatic clr_mon();
        hi_cnt = 0; done_cnt = 0; busy_cnt = 0; rise_cyc = -1; done_cyc = -1; nrise = 0;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; the start is sampled on the following rising edge.
    task automatic do_start(input logic [191:0] t, input int rep, input int dly, input bit ab);
        bit rf, bz, dn;
        int sc;
        logic [191:0] p;
        longint s;
        cfg_timing = t; cfg_repeats = 16'(rep); cfg_rep_delay = 32'(dly);
        start = 1'b1; abort = ab;
        model(cyc, rf, bz, dn, sc, p);
        if (!ab && !bz) begin
            prev_sc = sc; prev_ptd = p;
            s = tsum(t);
            t0 = cyc + 1; S = (s == 0) ? 1 : int'(s); G = (dly == 0) ? 1 : dly; R = rep;
            ab_at = 32'h7fffffff; tim = t; active = 1'b1;
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    logic [191:0] t1;
    int n0, target;

    initial begin
        t1 = pack(20, 40, 0, 10, 0, 20);
        repeat (2) @(negedge clk);
        check("rst_rf", RF_signal_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sc", shot_count, 0);
        check("rst_ptd_zero", pulse_timing_data == '0, 1);

        // Single shot, start on the first edge after reset release; config then scrambled.
        rst = 1'b0;
        clr_mon();
        do_start(t1, 1, 5, 1'b0);
        n0 = t0;
        cfg_timing = '1; cfg_repeats = 16'd7; cfg_rep_delay = 32'd9;
        wait_idle(300);
        check("one_rise_cyc", rise_cyc, n0 + 2);
        check("one_high", hi_cnt, 90);
        check("one_done_cyc", done_cyc, n0 + 92);
        check("one_done_cnt", done_cnt, 1);
        check("one_sc", shot_count, 1);
        check("one_ptd", pulse_timing_data == t1, 1);

        // Three shots, zero delay, with an ignored start mid-run.
        clr_mon();
        do_start(t1, 3, 0, 1'b0);
        repeat (50) @(negedge clk);
        do_start(pack(1, 1, 1, 1, 1, 1), 1, 1, 1'b0);
        wait_idle(1000);
        check("three_high", hi_cnt, 270);
        check("three_rises", nrise, 3);
        check("three_done_cnt", done_cnt, 1);
        check("three_sc", shot_count, 3);

        // start + abort together in IDLE: nothing starts, shot_count held.
        clr_mon();
        do_start(t1, 2, 1, 1'b1);
        repeat (4) @(negedge clk);
        check("sa_busy_cnt", busy_cnt, 0);
        check("sa_high", hi_cnt, 0);
        check("sa_sc_held", shot_count, 3);

        // Zero repeats.
        clr_mon();
        do_start(t1, 0, 5, 1'b0);
        wait_idle(20);
        check("zero_busy_cnt", busy_cnt, 2);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_high", hi_cnt, 0);
        check("zero_sc", shot_count, 0);

        // Abort at the 30th high cycle of shot 2.
        clr_mon();
        do_start(t1, 4, 3, 1'b0);
        target = t0 + 2 + 90 + 3 + 29;
        for (int i = 0; i < 500 && cyc < target; i++) @(negedge clk);
        check("ab_reach", cyc, target);
        check("ab_rf_before", RF_signal_valid, 1);
        abort = 1'b1; ab_at = cyc + 1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_rf", RF_signal_valid, 0);
        check("ab_busy", busy, 0);
        check("ab_sc", shot_count, 1);
        repeat (3) @(negedge clk);
        check("ab_done_cnt", done_cnt, 0);
        check("ab_high", hi_cnt, 120);

        // All-zero timing clamps each shot to one cycle.
        clr_mon();
        do_start('0, 3, 2, 1'b0);
        wait_idle(50);
        check("clamp_high", hi_cnt, 3);
        check("clamp_rises", nrise, 3);

        // Five short shots; phase cycles 0,1,2,3,0 when present.
        clr_mon();
        do_start(pack(1, 1, 1, 1, 0, 0), 5, 1, 1'b0);
        wait_idle(100);
        check("five_high", hi_cnt, 20);
        check("five_sc", shot_count, 5);
`ifdef PHASE_CYCLE_EN
        check("phase0", ph_rise[0], 0);
        check("phase1", ph_rise[1], 1);
        check("phase2", ph_rise[2], 2);
        check("phase3", ph_rise[3], 3);
        check("phase4", ph_rise[4], 0);
`endif

        // Reset asserted mid-shot clears outputs asynchronously.
        clr_mon();
        do_start(t1, 2, 1, 1'b0);
        repeat (10) @(negedge clk);
        check("rm_rf_before", RF_signal_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rm_rf", RF_signal_valid, 0);
        check("rm_busy", busy, 0);
        check("rm_done", done, 0);
        check("rm_sc", shot_count, 0);
        check("rm_ptd_zero", pulse_timing_data == '0, 1);
`ifdef PHASE_CYCLE_EN
        check("rm_phase", phase_offset, 0);
`endif
        active = 1'b0; prev_sc = 0; prev_ptd = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rm_idle", busy, 0);
        check("rm_no_done", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_sequence_scheduler.md
PULSE_SEQUENCE_SCHEDULER -- requirements
Module: pulse_sequence_scheduler

Interface
REQ-001 Parameter: REP_W, default 16, width of the shot-repeat count.
REQ-002 Port: clk  input  1  system clock; every register is updated on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  single-cycle request to begin a run of shots.
REQ-005 Port: abort  input  1  terminates the current run immediately.
REQ-006 Port: cfg_timing  input  192  six 32-bit pulse/delay fields, packed [191:160] down to [31:0].
REQ-007 Port: cfg_repeats  input  REP_W  number of shots to fire.
REQ-008 Port: cfg_rep_delay  input  32  number of idle cycles between shots.
REQ-009 Port: pulse_timing_data  output  192  timing word latched for the three_pulse core.
REQ-010 Port: RF_signal_valid  output  1  shot-enable signal to the three_pulse core.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done  output  1  one-cycle pulse when a run completes normally.
REQ-013 Port: shot_count  output  REP_W  number of shots completed in the current or most recent run.

Function
REQ-014 States SHALL be IDLE, LOAD, RUN, GAP and FIN.
REQ-015 In IDLE, start SHALL latch cfg_timing, cfg_repeats and cfg_rep_delay, clear shot_count, and move to LOAD on the next edge.
REQ-016 Latched values SHALL stay constant until the next accepted start; config changes during a run have no effect.
REQ-017 In LOAD, seq_cycles SHALL be computed as the 35-bit unsigned sum of the six fields, clamped to a minimum of 1.
REQ-018 In LOAD, pulse_timing_data SHALL be driven from the latch, and the next state is RUN, or FIN if latched repeats = 0.
REQ-019 In RUN, RF_signal_valid SHALL be high for exactly seq_cycles consecutive cycles.
REQ-020 The edge that ends RUN SHALL increment shot_count.
REQ-021 From RUN, the next state SHALL be FIN if shot_count reaches repeats, otherwise GAP.
REQ-022 In GAP, RF_signal_valid SHALL be low for max(cfg_rep_delay, 1) cycles, then the next state is RUN.
REQ-023 RF_signal_valid SHALL therefore always have at least one low cycle between shots, so the core re-arms.
REQ-024 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-025 RF_signal_valid SHALL be a registered output with no combinational path from any input.
REQ-026 Latency from start (sampled at edge N) to RF_signal_valid rising SHALL be exactly 2 edges (N+2).
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in any state SHALL force IDLE on the next edge.
REQ-029 On abort: RF_signal_valid goes low at that same edge, done is not pulsed, and shot_count holds.
REQ-030 If start and abort are high in the same IDLE cycle, abort SHALL win and the run is not started.
REQ-031 Counters SHALL NOT wrap: the RUN counter is 35 bits, the GAP counter 32 bits, and shot_count is REP_W bits, compared for equality only.

Reset
REQ-032 While rst is high, the state SHALL be IDLE and every output SHALL be 0, including pulse_timing_data and shot_count.
REQ-033 rst asserted mid-run SHALL drop RF_signal_valid asynchronously, with no done pulse.
REQ-034 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-035 Macro PHASE_CYCLE_EN, when defined, SHALL add output phase_offset [1:0], reset 0.
REQ-036 With PHASE_CYCLE_EN, phase_offset SHALL be cleared on an accepted start, incremented modulo 4 at the end of each RUN, and held stable throughout RUN.
REQ-037 Without PHASE_CYCLE_EN, the phase_offset port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-038 Timing word 20,40,0,10,0,20 with repeats=1 and delay=5, start -> RF_signal_valid high for 90 cycles starting 2 edges after start, then done one cycle later, shot_count=1.
REQ-039 Same timing with repeats=3 and delay=0 -> three 90-cycle highs separated by single low cycles, one done, shot_count=3.
REQ-040 Repeats=0, start -> no RF_signal_valid high, busy high for 2 cycles, done pulses, shot_count=0.
REQ-041 Repeats=4, abort asserted in shot 2 at its 30th high cycle -> RF_signal_valid low on the next edge, IDLE, shot_count=1, no done.
REQ-042 Second start during a run, and start+abort together in IDLE -> both ignored, waveform unchanged, busy stays/remains 0 respectively.
REQ-043 With PHASE_CYCLE_EN and repeats=5 -> phase_offset during shots reads 0,1,2,3,0; rst mid-shot -> all outputs 0 immediately.
